core_launch_ctrl: RTL and testbench

//  Host-side loader/launcher upstream of the processor cores. Accepts a byte stream from the host,

---
 rtl/core_launch_ctrl_pkg.sv | 40 ++++
 rtl/core_launch_ctrl_done_latch_bank.sv | 37 +++
 rtl/core_launch_ctrl.sv | 159 +++++++++++++++
 tb/tb_core_launch_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_launch_ctrl_pkg.sv
// Shared definitions for the core loader/launcher: FSM encoding, frame field
// widths and the instruction-length decode rule.
package core_launch_ctrl_pkg;

  localparam int INS_AW       = 8;
  localparam int DW           = 12;
  localparam int INS_LEN_ZERO = 256;
  localparam int INS_LW       = INS_AW + 1;

  typedef enum logic [4:0] {
    S_IDLE,
    S_INS_LEN,
    S_INS,
    S_DLEN_HI,
    S_DLEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_RBASE_HI,
    S_RBASE_LO,
    S_RLEN_HI,
    S_RLEN_LO,
    S_WAIT_RDY,
    S_START,
    S_RUN,
    S_RD_REQ,
    S_RD_WAIT,
    S_OUT
  } state_e;

  // A length byte of zero stands for a full 256-entry program.
  function automatic logic [INS_LW-1:0] ins_len_decode(input logic [7:0] len_byte);
    return (len_byte == 8'd0) ? INS_LW'(INS_LEN_ZERO) : {1'b0, len_byte};
  endfunction

  function automatic logic is_byte_state(input state_e s);
    return s inside {S_INS_LEN, S_INS, S_DLEN_HI, S_DLEN_LO, S_DATA_HI, S_DATA_LO,
                     S_RBASE_HI, S_RBASE_LO, S_RLEN_HI, S_RLEN_LO};
  endfunction

endpackage

// File: rtl/core_launch_ctrl_done_latch_bank.sv
// Per-core sticky done latches: set while enabled, cleared by clr_i,
// all_done_o high once every core has reported.
module done_latch_bank #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [N-1:0] done_i,
  output logic         all_done_o
);

  logic [N-1:0] latch_q, latch_d;

  // NOTE: default assignment first keeps every combinational block latch-free.
  always_comb begin
    latch_d = latch_q;
    if (clr_i) begin
      latch_d = '0;
    end else if (en_i) begin
      latch_d = latch_q | done_i;
    end
  end

  // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      latch_q <= '0;
    end else begin
      latch_q <= latch_d;
    end
  end

  assign all_done_o = &latch_q;

endmodule

// File: rtl/core_launch_ctrl.sv
// Host-side loader/launcher: loads instruction and data memory from a byte
// stream, launches all cores, waits for done, then streams a result window out.
module core_launch_ctrl
  import core_launch_ctrl_pkg::*;
#(
  parameter int N_CORES = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               host_valid,
  input  logic [7:0]         host_data,
  output logic               host_ready,
  output logic               ins_wr_en,
  output logic [INS_AW-1:0]  ins_addr,
  output logic [7:0]         ins_wr_data,
  output logic               dmem_wr_en,
  output logic [DW-1:0]      dmem_addr,
  output logic [DW-1:0]      dmem_wr_data,
  input  logic [DW-1:0]      dmem_rd_data,
  output logic               mem_sel,
  input  logic [N_CORES-1:0] core_ready,
  input  logic [N_CORES-1:0] core_done,
  output logic               core_start,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  input  logic               out_ready,
  output logic               busy,
  output logic               err
);

  localparam int              TO_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_END = TO_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [INS_LW-1:0]   ins_len_q;
  logic [INS_AW-1:0]   ins_cnt_q;
  logic [3:0]          hi_q;
  logic [DW-1:0]       dlen_q, data_cnt_q;
  logic [DW-1:0]       rbase_q, rlen_q, rd_cnt_q;
  logic [DW-1:0]       out_q;
  logic [TO_W-1:0]     run_cnt_q;
  logic                err_q;

  logic                hs, all_done, timeout_hit;
  logic                ins_last, data_last, rd_last;
  logic [DW-1:0]       field12;

  assign hs          = host_valid && is_byte_state(state_q);
  assign field12     = {hi_q, host_data};
  assign ins_last    = ({1'b0, ins_cnt_q} + INS_LW'(1)) == ins_len_q;
  assign data_last   = (data_cnt_q + DW'(1)) == dlen_q;
  assign rd_last     = (rd_cnt_q + DW'(1)) == rlen_q;
  assign timeout_hit = (TIMEOUT != 0) && (run_cnt_q == TO_END);

  done_latch_bank #(.N(N_CORES)) u_done_bank (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q == S_START),
    .en_i       (state_q == S_RUN),
    .done_i     (core_done),
    .all_done_o (all_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     state_d = S_INS_LEN;
      S_INS_LEN:  if (hs) state_d = S_INS;
      S_INS:      if (hs && ins_last) state_d = S_DLEN_HI;
      S_DLEN_HI:  if (hs) state_d = S_DLEN_LO;
      S_DLEN_LO:  if (hs) state_d = (field12 == '0) ? S_RBASE_HI : S_DATA_HI;
      S_DATA_HI:  if (hs) state_d = S_DATA_LO;
      S_DATA_LO:  if (hs) state_d = data_last ? S_RBASE_HI : S_DATA_HI;
      S_RBASE_HI: if (hs) state_d = S_RBASE_LO;
      S_RBASE_LO: if (hs) state_d = S_RLEN_HI;
      S_RLEN_HI:  if (hs) state_d = S_RLEN_LO;
      S_RLEN_LO:  if (hs) state_d = S_WAIT_RDY;
      S_WAIT_RDY: if (&core_ready) state_d = S_START;
      S_START:    state_d = S_RUN;
      S_RUN:      if (all_done || timeout_hit) state_d = (rlen_q == '0) ? S_IDLE : S_RD_REQ;
      S_RD_REQ:   state_d = S_RD_WAIT;
      S_RD_WAIT:  state_d = S_OUT;
      S_OUT:      if (out_ready) state_d = rd_last ? S_IDLE : S_RD_REQ;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    host_ready   = is_byte_state(state_q);
    ins_wr_en    = (state_q == S_INS) && host_valid;
    ins_addr     = ins_cnt_q;
    ins_wr_data  = host_data;
    dmem_wr_en   = (state_q == S_DATA_LO) && host_valid;
    dmem_wr_data = field12;
    dmem_addr    = data_cnt_q;
    if (state_q inside {S_RD_REQ, S_RD_WAIT, S_OUT}) begin
      dmem_addr = rbase_q + rd_cnt_q;
    end
    mem_sel      = (state_q != S_RUN);
    core_start   = (state_q == S_START);
    out_valid    = (state_q == S_OUT);
    out_data     = out_q;
    busy         = (state_q != S_IDLE);
    err          = err_q;
  end

  // Frame fields and counters; HI bytes only ever contribute their low nibble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ins_len_q  <= '0;
      ins_cnt_q  <= '0;
      hi_q       <= '0;
      dlen_q     <= '0;
      data_cnt_q <= '0;
      rbase_q    <= '0;
      rlen_q     <= '0;
      rd_cnt_q   <= '0;
      out_q      <= '0;
      run_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: err_q <= 1'b0;
        S_INS_LEN: if (hs) begin
          ins_len_q <= ins_len_decode(host_data);
          ins_cnt_q <= '0;
        end
        S_INS: if (hs) ins_cnt_q <= ins_cnt_q + INS_AW'(1);
        S_DLEN_HI, S_DATA_HI, S_RBASE_HI, S_RLEN_HI: if (hs) hi_q <= host_data[3:0];
        S_DLEN_LO: if (hs) begin
          dlen_q     <= field12;
          data_cnt_q <= '0;
        end
        S_DATA_LO:  if (hs) data_cnt_q <= data_cnt_q + DW'(1);
        S_RBASE_LO: if (hs) rbase_q <= field12;
        S_RLEN_LO:  if (hs) rlen_q <= field12;
        S_START:    run_cnt_q <= '0;
        S_RUN: begin
          run_cnt_q <= run_cnt_q + TO_W'(1);
          rd_cnt_q  <= '0;
          if (!all_done && timeout_hit) err_q <= 1'b1;
        end
        S_RD_WAIT: out_q <= dmem_rd_data;
        S_OUT:     if (out_ready) rd_cnt_q <= rd_cnt_q + DW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_launch_ctrl.sv
// Directed bench for core_launch_ctrl: scoreboard queues for memory writes and
// result words, a behavioural data memory, and immediate-assertion checks.
module tb_core_launch_ctrl;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_valid;
  logic [7:0]    host_data;
  logic          host_ready;
  logic          ins_wr_en;
  logic [7:0]    ins_addr;
  logic [7:0]    ins_wr_data;
  logic          dmem_wr_en;
  logic [11:0]   dmem_addr;
  logic [11:0]   dmem_wr_data;
  logic [11:0]   dmem_rd_data;
  logic          mem_sel;
  logic [N-1:0]  core_ready;
  logic [N-1:0]  core_done;
  logic          core_start;
  logic          out_valid;
  logic [11:0]   out_data;
  logic          out_ready;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_ins_wr = 0;

  logic [15:0] exp_ins_q[$];
  logic [23:0] exp_dmem_q[$];
  logic [11:0] exp_out_q[$];

  core_launch_ctrl #(.N_CORES(N), .TIMEOUT(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .host_valid   (host_valid),
    .host_data    (host_data),
    .host_ready   (host_ready),
    .ins_wr_en    (ins_wr_en),
    .ins_addr     (ins_addr),
    .ins_wr_data  (ins_wr_data),
    .dmem_wr_en   (dmem_wr_en),
    .dmem_addr    (dmem_addr),
    .dmem_wr_data (dmem_wr_data),
    .dmem_rd_data (dmem_rd_data),
    .mem_sel      (mem_sel),
    .core_ready   (core_ready),
    .core_done    (core_done),
    .core_start   (core_start),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pat(input logic [11:0] a);
    return a ^ 12'hA5C;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fail(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s: observed event missing or unexpected", tag);
  endtask

  // Behavioural data memory: preloaded pattern, loader writes, 1-cycle read latency.
  logic [11:0] bmem [4096];
  logic        bmem_init = 1'b0;
  always @(posedge clk) begin
    if (!bmem_init) begin
      for (int a = 0; a < 4096; a++) bmem[a] <= pat(12'(a));
      bmem_init <= 1'b1;
    end else if (dmem_wr_en) begin
      bmem[dmem_addr] <= dmem_wr_data;
    end
    dmem_rd_data <= bmem[dmem_addr];
  end

  always @(negedge clk) begin
    if (ins_wr_en) begin
      n_ins_wr++;
      if (exp_ins_q.size() == 0) fail("ins_unexpected");
      else check("ins_wr", {ins_addr, ins_wr_data}, exp_ins_q.pop_front());
    end
    if (dmem_wr_en) begin
      if (exp_dmem_q.size() == 0) fail("dmem_unexpected");
      else check("dmem_wr", {dmem_addr, dmem_wr_data}, exp_dmem_q.pop_front());
    end
    if (out_valid && out_ready) begin
      if (exp_out_q.size() == 0) fail("out_unexpected");
      else check("out_word", out_data, exp_out_q.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit hit = 1'b0;
    host_data  = b;
    host_valid = 1'b1;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (host_ready) begin
        @(posedge clk);
        #1;
        hit = 1'b1;
      end
    end
    host_valid = 1'b0;
    if (!hit) fail("host_handshake_timeout");
  endtask

  // 0: core_start, 1: idle, 2: out_valid, other: result queue drained.
  task automatic wait_cond(input int which, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      #1;
      case (which)
        0:       hit = core_start;
        1:       hit = !busy;
        2:       hit = out_valid;
        default: hit = (exp_out_q.size() == 0);
      endcase
    end
    if (!hit) fail(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    host_valid = 1'b0;
    host_data  = 8'h00;
    core_ready = '0;
    core_done  = '0;
    out_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_host_ready", host_ready, 0);
    check("rst_mem_sel", mem_sel, 1);
    check("rst_err", err, 0);
    check("rst_core_start", core_start, 0);
    check("rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Reset in the middle of INS abandons the frame
    send_byte(8'h04);
    exp_ins_q.push_back({8'd0, 8'h11});
    exp_ins_q.push_back({8'd1, 8'h22});
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    check("mid_ins_ready", host_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_host_ready", host_ready, 0);
    check("midrst_ins_wr_en", ins_wr_en, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Frame A: 3 instructions, 2 data words, read window 0xFFE..0x000
    send_byte(8'h03);
    exp_ins_q.push_back({8'd0, 8'hA1});
    exp_ins_q.push_back({8'd1, 8'hB2});
    exp_ins_q.push_back({8'd2, 8'hC3});
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hF0);
    send_byte(8'h02);
    exp_dmem_q.push_back({12'h000, 12'h123});
    exp_dmem_q.push_back({12'h001, 12'hFFF});
    send_byte(8'hF1);
    send_byte(8'h23);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h0F);
    send_byte(8'hFE);
    send_byte(8'h00);
    send_byte(8'h03);
    exp_out_q.push_back(pat(12'hFFE));
    exp_out_q.push_back(pat(12'hFFF));
    exp_out_q.push_back(12'h123);

    // Only one core ready; stray host byte must be refused
    core_ready = 2'b01;
    host_valid = 1'b1;
    host_data  = 8'h55;
    repeat (3) @(negedge clk);
    check("wait_host_ready", host_ready, 0);
    check("wait_core_start", core_start, 0);
    check("wait_busy", busy, 1);
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    core_ready = 2'b11;
    @(negedge clk);
    check("start_pre", core_start, 0);
    @(negedge clk);
    check("start_pulse", core_start, 1);
    core_done = 2'b11;
    @(posedge clk);
    #1 core_done = 2'b00;
    @(negedge clk);
    check("start_single", core_start, 0);
    check("run_mem_sel", mem_sel, 0);
    @(negedge clk);
    check("start_done_ignored", mem_sel, 0);
    out_ready = 1'b0;
    @(posedge clk);
    #1 core_done = 2'b01;
    @(posedge clk);
    #1 core_done = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("run_wait_core1", mem_sel, 0);
      @(posedge clk);
    end
    #1 core_done = 2'b10;
    @(negedge clk);
    check("run_core1_arrives", mem_sel, 0);
    @(posedge clk);
    #1 core_done = 2'b00;
    @(negedge clk);
    check("run_latched", mem_sel, 0);
    @(negedge clk);
    check("run_exit", mem_sel, 1);
    check("run_no_err", err, 0);

    // Read-back with a stalled sink
    wait_cond(2, "out_valid_timeout");
    for (int i = 0; i < 4; i++) begin
      check("out_hold_valid", out_valid, 1);
      check("out_hold_data", out_data, exp_out_q[0]);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_cond(3, "readback_drain_timeout");
    wait_cond(1, "idle_after_a_timeout");
    check("a_err", err, 0);

    // Frame B: INS_LEN=0 means 256 writes; DLEN=0 and RLEN=0
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) exp_ins_q.push_back({8'(i), 8'(i) ^ 8'h3C});
    for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'h3C);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_cond(0, "b_start_timeout");
    @(posedge clk);
    #1 core_done = 2'b11;
    @(posedge clk);
    #1 core_done = 2'b00;
    wait_cond(1, "b_idle_timeout");
    check("b_ins_count", n_ins_wr, 261);
    check("b_ins_queue", exp_ins_q.size(), 0);
    check("b_out_none", exp_out_q.size(), 0);

    // Frame C: cores never finish, timeout after 10 RUN cycles
    send_byte(8'h01);
    exp_ins_q.push_back({8'd0, 8'h7E});
    send_byte(8'h7E);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h00);
    send_byte(8'h01);
    exp_out_q.push_back(pat(12'h005));
    wait_cond(0, "c_start_timeout");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("to_run_err", err, 0);
      check("to_run_mem_sel", mem_sel, 0);
    end
    @(negedge clk);
    check("to_fire_err", err, 1);
    check("to_fire_mem_sel", mem_sel, 1);
    wait_cond(3, "c_readback_timeout");
    wait_cond(1, "c_idle_timeout");
    check("err_sticky_idle", err, 1);
    @(negedge clk);
    check("err_cleared", err, 0);
    check("next_frame_ready", host_ready, 1);

    check("end_ins_queue", exp_ins_q.size(), 0);
    check("end_dmem_queue", exp_dmem_q.size(), 0);
    check("end_out_queue", exp_out_q.size(), 0);
    check("end_ins_count", n_ins_wr, 262);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
